// File: rtl/sar_search_if.sv
// sar_search_if
// Bundles the search-controller handshake and the comparator-facing signals.
//   start          : request a new search (accepted only while idle)
//   trial          : registered operand driven to the comparator
//   cmp_gt/eq/lt   : comparator flags for trial vs target
//   busy/done      : search in progress / one-cycle completion pulse
//   result/found/err : committed outcome, held until the next accepted start
// Modports: slave = the controller, master = whoever drives start and the flags.
interface sar_search_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] trial;
   logic             cmp_gt;
   logic             cmp_eq;
   logic             cmp_lt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             found;
   logic             err;

   modport slave (
      input  start,
      input  cmp_gt,
      input  cmp_eq,
      input  cmp_lt,
      output trial,
      output busy,
      output done,
      output result,
      output found,
      output err
   );

   modport master (
      output start,
      output cmp_gt,
      output cmp_eq,
      output cmp_lt,
      input  trial,
      input  busy,
      input  done,
      input  result,
      input  found,
      input  err
   );
endinterface

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl
// Successive-approximation search controller. Drives a trial operand into an
// external combinational comparator and resolves one bit per clock, MSB
// first, from the GT/EQ/LT flags. It reports either an exact match or the
// largest value not exceeding the target.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : sar_search_if.slave (start, trial, cmp_*, busy, done, result,
//          found, err)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start; trial/result/found/err hold last values
// ST_SEARCH | sampling flags for the current trial, one bit per edge
// ST_DONE   | one-cycle done pulse, then back to idle unconditionally
module sar_search_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   sar_search_if.slave bus
);

   localparam int IDXW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEARCH = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam logic [IDXW-1:0]  IDX_MSB   = IDXW'(WIDTH - 1);
   localparam logic [IDXW-1:0]  IDX_ONE   = IDXW'(1);
   localparam logic [WIDTH-1:0] BIT_ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0] TRIAL_MSB = BIT_ONE << (WIDTH - 1);

   localparam logic [2:0] FLAGS_GT = 3'b100;
   localparam logic [2:0] FLAGS_EQ = 3'b010;
   localparam logic [2:0] FLAGS_LT = 3'b001;

   logic [1:0]       state_q,  state_d;
   logic [IDXW-1:0]  idx_q,    idx_d;
   logic [WIDTH-1:0] acc_q,    acc_d;
   logic [WIDTH-1:0] trial_q,  trial_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             found_q,  found_d;
   logic             err_q,    err_d;

   logic [2:0]       flags;
   logic [WIDTH-1:0] acc_new;
   logic [IDXW-1:0]  idx_dn;

   assign flags  = {bus.cmp_gt, bus.cmp_eq, bus.cmp_lt};
   assign idx_dn = idx_q - IDX_ONE;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      acc_d    = acc_q;
      trial_d  = trial_q;
      result_d = result_q;
      found_d  = found_q;
      err_d    = err_q;
      acc_new  = acc_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d  = ST_SEARCH;
               acc_d    = '0;
               idx_d    = IDX_MSB;
               trial_d  = TRIAL_MSB;
               result_d = '0;
               found_d  = 1'b0;
               err_d    = 1'b0;
            end
         end

         ST_SEARCH: begin
            case (flags)
               FLAGS_EQ: begin
                  result_d = trial_q;
                  found_d  = 1'b1;
                  state_d  = ST_DONE;
               end

               FLAGS_LT, FLAGS_GT: begin
                  // LT means trial <= target so the tentative bit stays set.
                  acc_new = (flags == FLAGS_LT) ? trial_q : acc_q;
                  acc_d   = acc_new;
                  if (idx_q == '0) begin
                     result_d = acc_new;
                     found_d  = 1'b0;
                     state_d  = ST_DONE;
                  end else begin
                     idx_d   = idx_dn;
                     trial_d = acc_new | (BIT_ONE << idx_dn);
                  end
               end

               default: begin
                  // Corrupt flags: report the bits committed so far.
                  err_d    = 1'b1;
                  found_d  = 1'b0;
                  result_d = acc_q;
                  state_d  = ST_DONE;
               end
            endcase
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= IDX_MSB;
         acc_q    <= '0;
         trial_q  <= '0;
         result_q <= '0;
         found_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         trial_q  <= trial_d;
         result_q <= result_d;
         found_q  <= found_d;
         err_q    <= err_d;
      end
   end

   assign bus.trial  = trial_q;
   assign bus.busy   = (state_q == ST_SEARCH);
   assign bus.done   = (state_q == ST_DONE);
   assign bus.result = result_q;
   assign bus.found  = found_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl
// Drives sar_search_ctrl against a behavioural comparator whose target may be
// a half-integer (kept doubled in target2). A closed-form model predicts the
// trial sequence and outcome of each search; a negedge monitor compares.
module tb_sar_search_ctrl;
   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0][W-1:0] trials;
      logic [7:0]          m;
      logic [W-1:0]        res;
      logic                fnd;
      logic                er;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sar_search_if #(.WIDTH(W)) sif ();

   sar_search_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif.slave)
   );

   always #5 clk = ~clk;

   int   target2  = 0;
   logic force_bad = 1'b0;
   logic [2:0] bad_pat = 3'b000;

   always_comb begin
      if (force_bad) begin
         {sif.cmp_gt, sif.cmp_eq, sif.cmp_lt} = bad_pat;
      end else begin
         sif.cmp_gt = (2 * int'(sif.trial)) >  target2;
         sif.cmp_eq = (2 * int'(sif.trial)) == target2;
         sif.cmp_lt = (2 * int'(sif.trial)) <  target2;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Closed form: the search tracks floor(target) bit by bit; an exact
   // nonzero integer target is hit once its lowest set bit is tried.
   function automatic exp_t model(int t2, int f);
      exp_t e;
      int   fl, m, tz;
      bit   exact;
      e     = '0;
      fl    = t2 / 2;
      exact = (t2 % 2 == 0) && (fl != 0);
      tz    = 0;
      if (exact) while (((fl >> tz) & 1) == 0) tz++;
      m = exact ? (W - tz) : W;
      if (f >= 1 && f <= m) begin
         e.m   = 8'(f);
         e.er  = 1'b1;
         e.fnd = 1'b0;
         e.res = W'(fl & ~((1 << (W - f + 1)) - 1));
      end else begin
         e.m   = 8'(m);
         e.er  = 1'b0;
         e.fnd = exact;
         e.res = W'(fl);
      end
      for (int j = 1; j <= int'(e.m); j++)
         e.trials[j-1] = W'((fl & ~((1 << (W - j + 1)) - 1)) | (1 << (W - j)));
      return e;
   endfunction

   exp_t sb[$];
   bit   no_sb = 1'b0;
   int   bcnt  = 0;
   bit   hold_v = 1'b0;
   exp_t last_e;

   always @(negedge clk) begin
      if (rst) begin
         bcnt   = 0;
         hold_v = 1'b0;
      end else if (sif.busy) begin
         hold_v = 1'b0;
         if (sb.size() == 0) begin
            if (!no_sb) chk("spurious_busy", int'(sif.busy), 0);
         end else begin
            chk("result_cleared", int'({sif.result, sif.found, sif.err}), 0);
            if (bcnt < int'(sb[0].m)) chk($sformatf("trial[%0d]", bcnt), int'(sif.trial), int'(sb[0].trials[bcnt]));
            else chk("busy_overrun", bcnt, int'(sb[0].m) - 1);
            bcnt++;
         end
      end else if (sif.done) begin
         if (sb.size() == 0) begin
            if (!no_sb) chk("spurious_done", int'(sif.done), 0);
         end else begin
            last_e = sb.pop_front();
            chk("result", int'(sif.result), int'(last_e.res));
            chk("found",  int'(sif.found),  int'(last_e.fnd));
            chk("err",    int'(sif.err),    int'(last_e.er));
            chk("samples", bcnt, int'(last_e.m));
            chk("trial_at_done", int'(sif.trial), int'(last_e.trials[last_e.m - 1]));
            hold_v = 1'b1;
         end
         bcnt = 0;
      end else if (hold_v) begin
         chk("hold_result", int'(sif.result), int'(last_e.res));
         chk("hold_flags",  int'({sif.found, sif.err}), int'({last_e.fnd, last_e.er}));
         chk("hold_trial",  int'(sif.trial), int'(last_e.trials[last_e.m - 1]));
      end
   end

   task automatic run_search(int t2, int f, logic [2:0] pat, bit pulse);
      int cnt;
      target2 = t2;
      bad_pat = pat;
      sb.push_back(model(t2, f));
      sif.start = 1'b1;
      @(negedge clk);
      sif.start = 1'b0;
      cnt = 1;
      force_bad = (f == 1);
      while (!sif.done && cnt < 40) begin
         @(negedge clk);
         cnt++;
         force_bad = (cnt == f);
         sif.start = pulse && (cnt == 3);
      end
      if (!sif.done) chk("done_timeout", cnt, 0);
      force_bad = 1'b0;
      // A start during the done cycle must be ignored.
      sif.start = pulse;
      @(negedge clk);
      sif.start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   logic [2:0] bad_list [5];

   initial begin
      sif.start = 1'b0;
      bad_list[0] = 3'b000; bad_list[1] = 3'b011; bad_list[2] = 3'b101;
      bad_list[3] = 3'b110; bad_list[4] = 3'b111;

      #3;
      chk("rst_trial",  int'(sif.trial),  0);
      chk("rst_busy",   int'(sif.busy),   0);
      chk("rst_done",   int'(sif.done),   0);
      chk("rst_result", int'(sif.result), 0);
      chk("rst_flags",  int'({sif.found, sif.err}), 0);
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);

      run_search(2 * 8'h5A, 0, 3'b000, 1'b0);
      run_search(2 * 8'hFF, 0, 3'b000, 1'b0);
      run_search(0,         0, 3'b000, 1'b0);
      run_search(75,        0, 3'b000, 1'b1);
      run_search(2 * 8'h5A, 3, 3'b000, 1'b0);

      // Asynchronous reset mid-search, between edges k+3 and k+4.
      no_sb   = 1'b1;
      target2 = 2 * 8'h5A;
      sif.start = 1'b1;
      @(negedge clk);
      sif.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_before_rst", int'(sif.busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_trial",  int'(sif.trial),  0);
      chk("arst_busy",   int'(sif.busy),   0);
      chk("arst_done",   int'(sif.done),   0);
      chk("arst_result", int'(sif.result), 0);
      chk("arst_flags",  int'({sif.found, sif.err}), 0);
      @(negedge clk);
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      no_sb = 1'b0;
      run_search(2 * 8'h01, 0, 3'b000, 1'b0);

      for (int i = 0; i < 30; i++) begin
         int t2, f;
         t2 = int'($urandom_range(0, 511));
         f  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W)) : 0;
         run_search(t2, f, bad_list[$urandom_range(0, 4)], ($urandom_range(0, 3) == 0));
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sar_search_ctrl.md
# sar_search_ctrl

Sequential successive-approximation controller that drives the operand side of a magnitude comparator and consumes its GT/EQ/LT flags. It binary-searches an unknown target held on the comparator's other operand, MSB first, one bit per clock. It reports the exact match, or the largest value not exceeding the target. It sits upstream of a combinational comparator instance and replaces manual operand sweeping in threshold-search and SAR-style conversion datapaths.

## Interface
- WIDTH, 8, bits in trial operand and result (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a new search; accepted only in IDLE
- trial  out  WIDTH  registered operand driven to the comparator (comparator computes trial vs target)
- cmp_gt  in  1  trial > target
- cmp_eq  in  1  trial == target
- cmp_lt  in  1  trial < target
- busy  out  1  search in progress
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  committed search result, held until next accepted start
- found  out  1  EQ observed during last search; held with result
- err  out  1  flags were not one-hot at a sample edge; held with result

## Operation
- States: IDLE, SEARCH, DONE. Internal bit index idx (WIDTH-1 down to 0) and committed-bits register acc.
- IDLE: start=1 at an edge → SEARCH; acc=0, idx=WIDTH-1, trial=1<<(WIDTH-1), busy=1, and result/found/err cleared to 0.
- SEARCH, each edge: sample {cmp_gt,cmp_eq,cmp_lt} for the current trial.
  - Exactly cmp_eq: result=trial, found=1 → DONE (early exit).
  - Exactly cmp_lt: bit idx kept (acc=trial).
  - Exactly cmp_gt: bit idx cleared (acc unchanged).
  - Any non-one-hot combination (000, 011, 111, ...): err=1, found=0, result=acc → DONE.
  - After LT/GT with idx>0: idx−1, trial=acc_new | (1<<(idx−1)).
  - After LT/GT with idx==0: result=acc_new, found=0 → DONE.
- DONE: done=1, busy=0 for exactly one cycle → IDLE unconditionally.
- trial holds its last driven value through DONE and IDLE until the next accepted start.
- start is ignored in SEARCH and DONE. No queuing.
- Floor semantics: without EQ, result = largest value whose trials all reported ≤ target. Target 0 yields result=0 with found=0, because trial 0 is never driven.

## Timing
- Reset (asynchronous, any state including mid-search): state=IDLE; trial=0, busy=0, done=0, result=0, found=0, err=0, acc=0, idx=WIDTH-1.
- trial is registered. The comparator is combinational, so flags for a trial driven at edge n are sampled at edge n+1. One bit is resolved per cycle.
- start seen at edge k:
  - busy high from k.
  - Bit WIDTH-1−j is evaluated at edge k+1+j.
  - Full search ends at edge k+WIDTH. done is high during cycle k+WIDTH to k+WIDTH+1, and IDLE is entered at edge k+WIDTH+1.
- EQ or err at edge k+m (1≤m≤WIDTH): DONE entered at k+m, and done is high for the following cycle.
- Earliest next accepted start: edge k+WIDTH+2, the first edge in IDLE. Worst-case throughput is one search per WIDTH+2 cycles.
- result, found, and err update on the same edge that enters DONE. They are stable while done=1 and afterwards.

## Test plan
- WIDTH=8, bench comparator target 0x5A, start at edge k → trials 80,40,60,50,58,5C,5A; EQ at k+7; done pulse next cycle; result=0x5A, found=1, err=0.
- Target 0xFF → trials 80,C0,E0,F0,F8,FC,FE,FF; EQ at k+8; result=0xFF, found=1.
- Target 0x00 → all eight trials GT; DONE at k+8; result=0x00, found=0, err=0; trial holds 0x01.
- Non-integer target 37.5 (model: GT if trial>37.5, else LT, never EQ) → result=0x25, found=0, done after exactly 8 sample edges. Then pulse start during busy and during done: no effect.
- Force flags 000 at the third sample edge (target 0x5A) → err=1, found=0, result=0x40, done pulse next cycle.
- Assert rst asynchronously mid-search (between edges k+3 and k+4) → all outputs 0 immediately. Release, start with target 0x01 → result=0x01, found=1 at k'+8.
